param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/rsa_fifo_pkg.sv | 13 +
 rtl/fifo_mem.sv | 26 ++
 rtl/param_fifo.sv | 167 ++++++++++++++++
 tb/tb_param_fifo.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_fifo_pkg.sv
// Shared FIFO constants and helpers for the RSA datapath FIFOs
// (LFSR feeder, primality-tester queues and the generic param_fifo).
package rsa_fifo_pkg;

    localparam int unsigned DEF_DATA_W = 32'd32;
    localparam int unsigned DEF_DEPTH  = 32'd16;

    // Occupancy counter width: must be able to hold the value DEPTH itself.
    function automatic int unsigned count_w(input int unsigned depth);
        return $clog2(depth) + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port: content is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with status flags, sticky error flags and
// selectable registered-read or first-word-fall-through output.
module param_fifo
    import rsa_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - 4,
    parameter int AE_LVL = 4,
    parameter int FWFT   = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     write,
    input  logic                     read,
    input  logic                     err_clr,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   data_count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LVL);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Reject illegal geometry while elaborating rather than misbehaving in silicon.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
        (AE_LVL >= AF_LVL) || (AF_LVL > DEPTH)) begin : g_param_err
        $error("param_fifo: illegal parameters DEPTH=%0d AF_LVL=%0d AE_LVL=%0d",
               DEPTH, AF_LVL, AE_LVL);
    end

    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic [DATA_W-1:0] rdata_s;

    // Status flags decode straight from the registered occupancy.
    assign fifo_full    = (count_r == DEPTH_C);
    assign fifo_empty   = (count_r == {CW{1'b0}});
    assign almost_full  = (count_r >= AF_C);
    assign almost_empty = (count_r <= AE_C);
    assign data_count   = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

    // A read frees a slot in the same cycle, so a write on full still lands.
    assign rd_acc_s = read && !fifo_empty;
    assign wr_acc_s = write && (!fifo_full || rd_acc_s);

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk    (clk),
        .we     (wr_acc_s),
        .waddr  (wr_ptr_r),
        .wdata  (data_in),
        .raddr  (rd_ptr_r),
        .rdata  (rdata_s)
    );

    // Pointers roll over naturally; DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Occupancy moves only when exactly one side is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky error flags; a fresh error in the clearing cycle takes priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (write && !wr_acc_s) begin
                overflow_r <= 1'b1;
            end else if (err_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (read && fifo_empty) begin
                underflow_r <= 1'b1;
            end else if (err_clr) begin
                underflow_r <= 1'b0;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head entry falls through whenever the FIFO holds data; zero otherwise.
        always_comb begin
            data_out   = {DATA_W{1'b0}};
            data_valid = 1'b0;
            if (!fifo_empty) begin
                data_out   = rdata_s;
                data_valid = 1'b1;
            end else begin
                data_out   = {DATA_W{1'b0}};
                data_valid = 1'b0;
            end
        end
    end else begin : g_reg_read
        logic [DATA_W-1:0] data_out_r;
        logic              data_valid_r;

        // Registered read: capture the head on an accepted read, else hold.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_out_r   <= {DATA_W{1'b0}};
                data_valid_r <= 1'b0;
            end else begin
                data_valid_r <= rd_acc_s;
                if (rd_acc_s) begin
                    data_out_r <= rdata_s;
                end else begin
                    data_out_r <= data_out_r;
                end
            end
        end

        assign data_out   = data_out_r;
        assign data_valid = data_valid_r;
    end

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo: a default registered-read
// instance and a small first-word-fall-through instance.
module tb_param_fifo;

    logic        clk;
    logic        reset_n;

    // Default instance (DATA_W=32, DEPTH=16, AF=12, AE=4, FWFT=0)
    logic [31:0] data_in;
    logic        write, read, err_clr;
    logic [31:0] data_out;
    logic        data_valid, fifo_full, fifo_empty, almost_full, almost_empty;
    logic [4:0]  data_count;
    logic        overflow, underflow;

    // FWFT instance (DATA_W=8, DEPTH=4, AF=3, AE=1)
    logic [7:0]  b_data_in;
    logic        b_write, b_read, b_err_clr;
    logic [7:0]  b_data_out;
    logic        b_data_valid, b_fifo_full, b_fifo_empty, b_almost_full, b_almost_empty;
    logic [2:0]  b_data_count;
    logic        b_overflow, b_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    param_fifo u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .write        (write),
        .read         (read),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .data_count   (data_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    param_fifo #(
        .DATA_W (8),
        .DEPTH  (4),
        .AF_LVL (3),
        .AE_LVL (1),
        .FWFT   (1)
    ) u_dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (b_data_in),
        .write        (b_write),
        .read         (b_read),
        .err_clr      (b_err_clr),
        .data_out     (b_data_out),
        .data_valid   (b_data_valid),
        .fifo_full    (b_fifo_full),
        .fifo_empty   (b_fifo_empty),
        .almost_full  (b_almost_full),
        .almost_empty (b_almost_empty),
        .data_count   (b_data_count),
        .overflow     (b_overflow),
        .underflow    (b_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        data_in   = 32'h0;
        write     = 1'b0;
        read      = 1'b0;
        err_clr   = 1'b0;
        b_data_in = 8'h0;
        b_write   = 1'b0;
        b_read    = 1'b0;
        b_err_clr = 1'b0;

        // ---------------- reset state ----------------
        #22;
        chk("rst_count",  32'(data_count), 32'd0);
        chk("rst_empty",  32'(fifo_empty), 32'd1);
        chk("rst_full",   32'(fifo_full), 32'd0);
        chk("rst_af",     32'(almost_full), 32'd0);
        chk("rst_ae",     32'(almost_empty), 32'd1);
        chk("rst_dout",   data_out, 32'h0);
        chk("rst_dv",     32'(data_valid), 32'd0);
        chk("rst_ovf",    32'(overflow), 32'd0);
        chk("rst_unf",    32'(underflow), 32'd0);
        chk("b_rst_dout", 32'(b_data_out), 32'h0);
        chk("b_rst_dv",   32'(b_data_valid), 32'd0);
        chk("b_rst_empty",32'(b_fifo_empty), 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // ---------------- fill 0x1..0x10 ----------------
        write = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            data_in = 32'(i);
            tick();
            chk("fill_count", 32'(data_count), 32'(i));
            chk("fill_af", 32'(almost_full), (i >= 12) ? 32'd1 : 32'd0);
            chk("fill_ae", 32'(almost_empty), (i <= 4) ? 32'd1 : 32'd0);
        end
        chk("fill_full", 32'(fifo_full), 32'd1);
        data_in = 32'h11;
        tick();
        chk("ovf_set",   32'(overflow), 32'd1);
        chk("ovf_count", 32'(data_count), 32'd16);
        write   = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // ---------------- drain ----------------
        for (int i = 1; i <= 16; i++) begin
            read = 1'b1;
            tick();
            chk("drain_dout",  data_out, 32'(i));
            chk("drain_dv",    32'(data_valid), 32'd1);
            chk("drain_count", 32'(data_count), 32'(16 - i));
            read = 1'b0;
            tick();
            chk("drain_dv_lo", 32'(data_valid), 32'd0);
            chk("drain_hold",  data_out, 32'(i));
        end
        read = 1'b1;
        tick();
        chk("unf_set",  32'(underflow), 32'd1);
        chk("unf_dv",   32'(data_valid), 32'd0);
        chk("unf_hold", data_out, 32'h10);
        chk("unf_empty",32'(fifo_empty), 32'd1);
        // set wins over clear in the same cycle
        err_clr = 1'b1;
        tick();
        chk("unf_set_wins", 32'(underflow), 32'd1);
        read = 1'b0;
        tick();
        err_clr = 1'b0;
        chk("unf_clr", 32'(underflow), 32'd0);

        // ---------------- write + read on empty ----------------
        write   = 1'b1;
        read    = 1'b1;
        data_in = 32'h77;
        tick();
        write = 1'b0;
        chk("wre_count", 32'(data_count), 32'd1);
        chk("wre_unf",   32'(underflow), 32'd1);
        chk("wre_dv",    32'(data_valid), 32'd0);
        tick();
        read    = 1'b0;
        chk("wre_dout", data_out, 32'h77);
        chk("wre_dv2",  32'(data_valid), 32'd1);
        chk("wre_cnt0", 32'(data_count), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // ---------------- full pass-through ----------------
        write = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_in = 32'h100 + 32'(i);
            tick();
        end
        chk("pt_full", 32'(fifo_full), 32'd1);
        data_in = 32'hAA;
        read    = 1'b1;
        tick();
        write = 1'b0;
        chk("pt_count", 32'(data_count), 32'd16);
        chk("pt_ovf",   32'(overflow), 32'd0);
        chk("pt_dout",  data_out, 32'h100);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("pt_drain", data_out, 32'h100 + 32'(i));
        end
        tick();
        read = 1'b0;
        chk("pt_aa",    data_out, 32'hAA);
        chk("pt_empty", 32'(fifo_empty), 32'd1);

        // ---------------- wrap ----------------
        for (int k = 0; k < 40; k++) begin
            write   = 1'b1;
            data_in = 32'h200 + 32'(k);
            tick();
            write = 1'b0;
            chk("wrap_cnt1", 32'(data_count), 32'd1);
            read = 1'b1;
            tick();
            read = 1'b0;
            chk("wrap_dout", data_out, 32'h200 + 32'(k));
            chk("wrap_cnt0", 32'(data_count), 32'd0);
        end

        // ---------------- reset mid-burst ----------------
        read = 1'b1;
        tick();
        read = 1'b0;
        chk("mb_unf_pre", 32'(underflow), 32'd1);
        write = 1'b1;
        for (int k = 0; k < 7; k++) begin
            data_in = 32'h300 + 32'(k);
            tick();
        end
        chk("mb_count_pre", 32'(data_count), 32'd7);
        #2 reset_n = 1'b0;
        #1;
        chk("mb_count", 32'(data_count), 32'd0);
        chk("mb_empty", 32'(fifo_empty), 32'd1);
        chk("mb_dout",  data_out, 32'h0);
        chk("mb_unf",   32'(underflow), 32'd0);
        chk("mb_ovf",   32'(overflow), 32'd0);
        chk("mb_dv",    32'(data_valid), 32'd0);
        chk("mb_af",    32'(almost_full), 32'd0);
        write = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        write   = 1'b1;
        data_in = 32'h3C;
        tick();
        write = 1'b0;
        chk("post_count", 32'(data_count), 32'd1);
        read = 1'b1;
        tick();
        read = 1'b0;
        chk("post_dout", data_out, 32'h3C);
        chk("post_dv",   32'(data_valid), 32'd1);

        // ---------------- FWFT instance ----------------
        b_write   = 1'b1;
        b_data_in = 8'h5A;
        tick();
        b_write = 1'b0;
        chk("b_dout",  32'(b_data_out), 32'h5A);
        chk("b_dv",    32'(b_data_valid), 32'd1);
        chk("b_count", 32'(b_data_count), 32'd1);
        tick();
        chk("b_hold",  32'(b_data_out), 32'h5A);
        b_read = 1'b1;
        tick();
        b_read = 1'b0;
        chk("b_empty", 32'(b_fifo_empty), 32'd1);
        chk("b_dv_lo", 32'(b_data_valid), 32'd0);
        b_write   = 1'b1;
        b_data_in = 8'hC1;
        tick();
        b_data_in = 8'hC2;
        tick();
        b_write = 1'b0;
        chk("b_head",  32'(b_data_out), 32'hC1);
        b_read = 1'b1;
        tick();
        b_read = 1'b0;
        chk("b_next",  32'(b_data_out), 32'hC2);
        chk("b_cnt1",  32'(b_data_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
